// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and helpers for the interrupt controller
package irq_pkg;

  localparam int IRQ_ID_W = 4;
  localparam int IRQ_MAX  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [IRQ_ID_W-1:0] prio_enc(input logic [IRQ_MAX-1:0] v);
    prio_enc = '0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      if (v[i]) prio_enc = IRQ_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one channel of 2-FF synchroniser plus rising-edge detect
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - N-channel edge-triggered fixed-priority interrupt controller
module irq_controller #(
  parameter int               N_IRQ      = 4,
  parameter int               VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE   = 10'h3F0,
  parameter int               VEC_STRIDE = 4,
  parameter logic [N_IRQ-1:0] EN_RST     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             en_we,
  input  logic [N_IRQ-1:0] en_wdata,
  input  logic             lost_clr,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic [3:0]       irq_id,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] irq_en,
  output logic [N_IRQ-1:0] lost,
  output logic             busy
);

  import irq_pkg::*;

  irq_state_t           state;
  logic [N_IRQ-1:0]     rise;
  logic [N_IRQ-1:0]     eligible;
  logic [N_IRQ-1:0]     ack_mask;
  logic [IRQ_MAX-1:0]   elig_ext;
  logic [IRQ_ID_W-1:0]  winner;
  logic [VEC_W-1:0]     vec_next;
  logic                 ack_fire;

  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_sync
    irq_sync_edge u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in[gi]),
      .rise  (rise[gi])
    );
  end

  assign ack_fire = (state == ST_REQ) && irq_ack;

  always_comb begin
    eligible = pending & irq_en;
    elig_ext = '0;
    elig_ext[N_IRQ-1:0] = eligible;
    winner   = prio_enc(elig_ext);
    vec_next = VEC_BASE + VEC_W'(winner) * VEC_W'(VEC_STRIDE);
    ack_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (ack_fire && (irq_id == IRQ_ID_W'(i))) ack_mask[i] = 1'b1;
    end
  end

  // A new edge beats the ack-clear, and an edge racing its own ack is not a loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      lost    <= '0;
      irq_en  <= EN_RST;
    end else begin
      pending <= (pending & ~ack_mask) | rise;
      lost    <= (lost_clr ? '0 : lost) | (rise & pending & ~ack_mask);
      if (en_we) irq_en <= en_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
      irq_id  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            irq_id  <= winner;
            irq_vec <= vec_next;
            irq_req <= 1'b1;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (irq_eoi) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          irq_req <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised interrupt controller between external interrupt lines and the single-cycle CPU; it replaces the CPU's two hard-wired `intr1`/`intr2` inputs with N synchronised, edge-triggered, maskable, fixed-priority channels. It latches events as sticky pending bits and presents one request at a time with a vector address. Service follows a req/ack/eoi handshake, so interrupts never nest.

## Interface
- `N_IRQ`, 4: number of interrupt channels (1..16)
- `VEC_W`, 10: vector (PC) width
- `VEC_BASE`, 10'h3F0: vector of channel 0
- `VEC_STRIDE`, 4: vector spacing between channels
- `EN_RST`, all ones: reset value of `irq_en`

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `irq_in`  in  N_IRQ  raw, asynchronous external interrupt lines
- `en_we`  in  1  write strobe for the enable register
- `en_wdata`  in  N_IRQ  new enable mask (1 = channel enabled)
- `lost_clr`  in  1  clears all `lost` bits
- `irq_ack`  in  1  CPU accepts the current request (one-cycle pulse)
- `irq_eoi`  in  1  CPU finished the ISR (reti; one-cycle pulse)
- `irq_req`  out  1  request to CPU
- `irq_vec`  out  VEC_W  ISR address, valid while `irq_req`=1
- `irq_id`  out  4  index of the requested or in-service channel
- `pending`  out  N_IRQ  sticky pending bits
- `irq_en`  out  N_IRQ  current enable register
- `lost`  out  N_IRQ  sticky flags: an edge arrived while that channel was already pending
- `busy`  out  1  state is SERVICE

## Operation
- Per channel: 2-FF synchroniser, then a third flop for rising-edge detect (`s2 & ~s3`).
- Edge on channel i sets `pending[i]`. If `pending[i]` is already 1, set `lost[i]` instead. `lost` clears only on `lost_clr`; a set in the same cycle wins.
- Eligible set = `pending & irq_en`. Winner = lowest index in the eligible set.
- FSM states:
  - IDLE: if the eligible set is non-empty, latch winner into `irq_id`, latch `irq_vec = VEC_BASE + id*VEC_STRIDE` (truncated to VEC_W), go to REQ.
  - REQ: `irq_req`=1. `irq_vec`/`irq_id` stay frozen until `irq_ack`, even if a higher-priority channel arrives or the winner is disabled. On `irq_ack`, clear `pending[irq_id]` and go to SERVICE.
  - SERVICE: `irq_req`=0, `busy`=1, `irq_id` holds the in-service channel. Edges keep latching. On `irq_eoi`, go to IDLE.
- Ignored pulses: `irq_ack` outside REQ, `irq_eoi` outside SERVICE.
- Ack-clear on channel i coinciding with a new edge on i: the set wins, so `pending[i]` stays 1 and `lost[i]` is not set.
- `en_we` takes effect the next cycle and never cancels a committed REQ.
- Reset mid-operation: state → IDLE, all flops cleared, `irq_en` = EN_RST. Events in flight are discarded.

## Timing
- Reset values: `irq_req`=0, `irq_vec`=0, `irq_id`=0, `pending`=0, `lost`=0, `busy`=0, `irq_en`=EN_RST, synchroniser flops 0.
- Latency: if `irq_in` is first sampled high at edge k, then `pending` is set after edge k+2 and `irq_req`=1 after edge k+3.
- `irq_ack` sampled at edge m: `irq_req` falls and `busy` rises after m.
- `irq_eoi` sampled at edge m: IDLE after m. A further eligible channel gives `irq_req` after m+1.
- Minimum `irq_in` high/low width is 2 clock periods; shorter pulses may be missed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `irq_pkg`: FSM state enum (IDLE, REQ, SERVICE), `IRQ_ID_W`=4, and a priority-encoder function returning the lowest set index.
- Sub-module `irq_sync_edge`: one channel of 2-FF synchroniser plus edge detect, instantiated N_IRQ times via generate.
- The FSM, pending/lost/enable registers and vector arithmetic live in the top module.

## Test plan
All scenarios use the defaults: N_IRQ=4, VEC_BASE=10'h3F0, VEC_STRIDE=4.
- Single event: `irq_in[2]` 0→1 → `irq_req`=1 after 3 edges, `irq_vec`=10'h3F8, `irq_id`=2. After `irq_ack`, `pending`=4'b0000 and `busy`=1. After `irq_eoi`, IDLE.
- Priority: channels 3 and 1 rise in the same cycle → vector 10'h3F4 served first. After eoi, 10'h3FC follows, with `irq_req` rising 2 edges after eoi.
- Frozen request: in REQ for channel 3, raise channel 0 → `irq_vec` stays 10'h3FC until ack. Channel 0 is served after eoi.
- Masking: `en_wdata`=4'b1110 written, then `irq_in[0]` rises → `pending[0]`=1, no `irq_req`. Writing 4'b1111 → `irq_req` with vector 10'h3F0.
- Lost, and ack/edge collision:
  - Second edge on channel 1 while pending → `lost[1]`=1.
  - Edge on channel 2 synchronised in the ack cycle of channel 2 → `pending[2]` stays 1.
  - `lost_clr` → `lost`=0.
- Reset mid-service: assert `reset` in SERVICE for 10 time units → all outputs at reset values immediately; no request until a new edge arrives.
